frame_loader: RTL
=================

FRAME_LOADER -- requirements
Module: frame_loader

Interface
REQ-001 Parameters (name, default, meaning) SHALL be: WIDTH, 6, image columns; HEIGHT, 6, image rows; XSZ, 3, x-counter width; YSZ, 3, y-counter width; ADDR_SZ, 6, frame-RAM address width; COL_SZ, 3, pixel width.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset; the ports are clk and resetn.
REQ-003 Ports (name, direction, width, meaning) SHALL be:
- clk, in, 1, rising-edge clock.
- resetn, in, 1, asynchronous active-low reset.
- start, in, 1, begin one frame operation; sampled in IDLE only.
- clearMode, in, 1, sampled with start; 1 = fill the frame with 0, 0 = load the frame from the pixel stream.
- abort, in, 1, synchronous; cancels the operation in progress.
- pixIn, in, COL_SZ, stream pixel value.
- pixValid, in, 1, pixIn valid.
- pixReady, out, 1, block accepts pixIn this cycle.
- wrEn, out, 1, frame-RAM write enable.
- wrAddr, out, ADDR_SZ, frame-RAM write address.
- wrData, out, COL_SZ, frame-RAM write data.
- xOut, out, XSZ, current column counter.
- yOut, out, YSZ, current row counter.
- busy, out, 1, operation in progress.
- frameDone, out, 1, one-cycle pulse when the last pixel has been written.

Function
REQ-004 The state machine SHALL have the states IDLE, CLEAR, LOAD and DONE.
REQ-005 IDLE with start=1 SHALL go to CLEAR if clearMode=1, else to LOAD, and SHALL zero xOut and yOut on the same edge.
REQ-006 While in IDLE, start=0 SHALL keep the block in IDLE.
REQ-007 start SHALL be ignored in every state other than IDLE.
REQ-008 pixReady SHALL equal 1 only in LOAD, combinationally; it SHALL be 0 in IDLE, CLEAR and DONE.
REQ-009 A beat is accepted at a rising edge when pixValid=1 and pixReady=1.
- pixValid=0 in LOAD SHALL hold the counters and issue no write.
REQ-010 In CLEAR, one pixel SHALL advance every cycle with no handshake; the write data is 0.
REQ-011 Each accepted beat (LOAD) or advanced pixel (CLEAR) SHALL produce, at the next rising edge, registered outputs:
- wrEn=1;
- wrAddr = yOut*WIDTH + xOut, using the counter values of the accepting cycle;
- wrData = pixIn (LOAD) or 0 (CLEAR).
This is exactly one cycle of write latency. wrEn SHALL be 0 in every other cycle.
REQ-012 wrAddr arithmetic SHALL be unsigned and ADDR_SZ wide; for WIDTH=6 it SHALL be implemented as y*4 + y*2 + x; the result never exceeds WIDTH*HEIGHT-1 (35).
REQ-013 Counter stepping on each advance:
- xOut SHALL increment by 1.
- At xOut=WIDTH-1, xOut SHALL wrap to 0 and yOut SHALL increment by 1.
REQ-014 When the pixel at (WIDTH-1, HEIGHT-1) advances, the block SHALL go to DONE and leave xOut=0, yOut=0; the counters SHALL never go past row HEIGHT-1.
REQ-015 DONE SHALL last exactly one cycle.
- The write of the last pixel (wrEn=1, wrAddr=35) SHALL occur in that cycle.
- frameDone=1 in that cycle only; the next state is IDLE.
REQ-016 busy SHALL be 1 in CLEAR, LOAD and DONE, and 0 in IDLE.
REQ-017 abort=1 in CLEAR or LOAD SHALL take priority over advancing.
- The next state is IDLE, with no acceptance in that cycle.
- xOut and yOut hold their values.
- frameDone is not asserted.
- A write already registered from the previous cycle SHALL still complete.
REQ-018 abort SHALL have no effect in IDLE and in DONE.
REQ-019 A frame load SHALL take exactly WIDTH*HEIGHT accepted beats; a clear SHALL take exactly WIDTH*HEIGHT+1 cycles from leaving IDLE to frameDone.

Reset
REQ-020 resetn=0 SHALL asynchronously force:
- state IDLE;
- xOut=0, yOut=0;
- wrEn=0, wrAddr=0, wrData=0;
- pixReady=0, busy=0, frameDone=0.
REQ-021 Reset asserted mid-operation SHALL cancel any pending write; the first operation after reset SHALL start only on a new start pulse.

Verification
REQ-022 The bench SHALL cover these scenarios:
- Load, continuous valid: start=1, clearMode=0, then pixValid=1 with pixIn=k%8 for k=0..35 -> 36 writes, wrAddr 0..35 in order, wrData=k%8, frameDone pulses once in the cycle after beat 35 is accepted, pixReady drops.
- Gapped valid: pixValid toggling 1,0,1,0 -> no write after a pixValid=0 cycle, addresses stay contiguous, and the total count is still 36.
- Clear: start=1, clearMode=1 -> 36 consecutive writes with wrData=0, wrAddr 0..35, frameDone exactly 37 cycles after start is sampled, and pixReady stays 0 throughout.
- Row wrap: after beat 5 is accepted -> xOut=0, yOut=1; beat 6 -> wrAddr=6.
- Abort: abort=1 after beat 10 -> busy=0 next cycle, no frameDone, and a start pulse during the abort cycle is ignored.
- Reset mid-load: resetn=0 after beat 20 -> all outputs immediately 0; a new start afterwards restarts at wrAddr=0.

Source files
------------

// File: rtl/frame_loader.sv
`default_nettype none
// ============================================================================
// Module      : frame_loader
// Description : Walks a WIDTH x HEIGHT frame in raster order, either filling
//               it with zero or loading it from a ready/valid pixel stream,
//               and issues one registered frame-RAM write per pixel.
// Revision    : 1.0 - initial release
// ============================================================================
module frame_loader #(
    parameter int WIDTH   = 6,
    parameter int HEIGHT  = 6,
    parameter int XSZ     = 3,
    parameter int YSZ     = 3,
    parameter int ADDR_SZ = 6,
    parameter int COL_SZ  = 3
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               start,
    input  logic               clearMode,
    input  logic               abort,
    input  logic [COL_SZ-1:0]  pixIn,
    input  logic               pixValid,
    output logic               pixReady,
    output logic               wrEn,
    output logic [ADDR_SZ-1:0] wrAddr,
    output logic [COL_SZ-1:0]  wrData,
    output logic [XSZ-1:0]     xOut,
    output logic [YSZ-1:0]     yOut,
    output logic               busy,
    output logic               frameDone
);

    localparam logic [1:0]     c_IDLE   = 2'd0;
    localparam logic [1:0]     c_CLEAR  = 2'd1;
    localparam logic [1:0]     c_LOAD   = 2'd2;
    localparam logic [1:0]     c_DONE   = 2'd3;
    localparam logic [XSZ-1:0] c_LAST_X = XSZ'(WIDTH - 1);
    localparam logic [YSZ-1:0] c_LAST_Y = YSZ'(HEIGHT - 1);

    logic [1:0]         r_state;
    logic [1:0]         w_nextState;
    logic               w_advance;
    logic               w_lastPixel;
    logic [ADDR_SZ-1:0] w_addr;

    assign w_lastPixel = (xOut == c_LAST_X) && (yOut == c_LAST_Y);

    // Row-major address; the six-column case avoids a multiplier.
    generate
        if (WIDTH == 6) begin : g_shiftAdd
            assign w_addr = (ADDR_SZ'(yOut) << 2) + (ADDR_SZ'(yOut) << 1) + ADDR_SZ'(xOut);
        end else begin : g_mult
            assign w_addr = ADDR_SZ'(yOut) * ADDR_SZ'(WIDTH) + ADDR_SZ'(xOut);
        end
    endgenerate

    always_comb begin
        w_nextState = r_state;
        w_advance   = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (start) begin
                    w_nextState = clearMode ? c_CLEAR : c_LOAD;
                end
            end
            c_CLEAR, c_LOAD: begin
                // abort wins over any pixel advance in the same cycle
                if (abort) begin
                    w_nextState = c_IDLE;
                end else if ((r_state == c_CLEAR) || pixValid) begin
                    w_advance = 1'b1;
                    if (w_lastPixel) begin
                        w_nextState = c_DONE;
                    end
                end
            end
            c_DONE:  w_nextState = c_IDLE;
            default: w_nextState = c_IDLE;
        endcase
    end

    assign pixReady  = (r_state == c_LOAD);
    assign busy      = (r_state != c_IDLE);
    assign frameDone = (r_state == c_DONE);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            xOut <= '0;
            yOut <= '0;
        end else if ((r_state == c_IDLE) && start) begin
            xOut <= '0;
            yOut <= '0;
        end else if (w_advance) begin
            if (xOut == c_LAST_X) begin
                xOut <= '0;
                yOut <= (yOut == c_LAST_Y) ? '0 : yOut + 1'b1;
            end else begin
                xOut <= xOut + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wrEn   <= 1'b0;
            wrAddr <= '0;
            wrData <= '0;
        end else begin
            wrEn <= w_advance;
            if (w_advance) begin
                wrAddr <= w_addr;
                wrData <= (r_state == c_CLEAR) ? '0 : pixIn;
            end
        end
    end

endmodule
`default_nettype wire
